// File: rtl/rx_synch_ctrl_if.sv
// Link between the RX frame sequencer and the fine time synchroniser.
// master = synchroniser/sample side, slave = rx_synch_ctrl.
interface rx_synch_ctrl_if;
    logic smp_val;
    logic syn_run;
    logic syn_stb;
    logic syn_ack;
    logic syn_cyc;

    modport master (
        output smp_val,
        output syn_run,
        output syn_stb,
        output syn_ack,
        input  syn_cyc
    );

    modport slave (
        input  smp_val,
        input  syn_run,
        input  syn_stb,
        input  syn_ack,
        output syn_cyc
    );
endinterface

// File: rtl/rx_synch_ctrl.sv
// Frame sequencer: arms the fine time synchroniser on packet detect,
// supervises preamble search, counts payload symbols, closes the frame.
module rx_synch_ctrl #(
    parameter int SYM_LEN = 1024,
    parameter int TIMEOUT = 2048,
    parameter int GAP     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                pkt_det,
    input  logic [7:0]          n_sym_cfg,
    rx_synch_ctrl_if.slave      syn,
    output logic                busy,
    output logic [2:0]          state_o,
    output logic [7:0]          sym_cnt,
    output logic                frame_done,
    output logic                timeout_err
);

    localparam int SW = $clog2(TIMEOUT);
    localparam int PW = $clog2(SYM_LEN);
    localparam int GW = $clog2(GAP);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        SEARCH  = 3'd2,
        PAYLOAD = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t        state, state_d;
    logic [1:0]    arm_cnt, arm_d;
    logic [SW-1:0] srch_cnt, srch_d;
    logic [PW-1:0] smp_cnt, smp_d;
    logic [GW-1:0] gap_cnt, gap_d;
    logic [7:0]    sym_d, n_lat, nlat_d, sym_inc;
    logic          done_d, tout_d;
    logic          run_q, beat, cyc_q;

    assign beat    = syn.syn_stb & syn.syn_ack;
    assign sym_inc = (sym_cnt == 8'hFF) ? sym_cnt : sym_cnt + 8'd1;

    always_comb begin
        state_d = state;
        arm_d   = arm_cnt;
        srch_d  = srch_cnt;
        smp_d   = smp_cnt;
        gap_d   = gap_cnt;
        sym_d   = sym_cnt;
        nlat_d  = n_lat;
        done_d  = 1'b0;
        tout_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pkt_det && enable) begin
                    state_d = ARM;
                    arm_d   = 2'd0;
                    sym_d   = 8'd0;
                    nlat_d  = (n_sym_cfg == 8'd0) ? 8'd1 : n_sym_cfg;
                end
            end
            ARM: begin
                if (!enable) begin
                    state_d = DRAIN;
                    gap_d   = '0;
                end else if (syn.syn_run) begin
                    state_d = SEARCH;
                    srch_d  = '0;
                end else if (arm_cnt == 2'd3) begin
                    state_d = IDLE;
                    tout_d  = 1'b1;
                end else begin
                    arm_d = arm_cnt + 2'd1;
                end
            end
            SEARCH: begin
                // a falling syn_run beats a simultaneous timeout
                if (!enable) begin
                    state_d = DRAIN;
                    gap_d   = '0;
                end else if (run_q && !syn.syn_run) begin
                    state_d = PAYLOAD;
                    smp_d   = '0;
                end else if (syn.smp_val) begin
                    if (srch_cnt == SW'(TIMEOUT - 1)) begin
                        state_d = DRAIN;
                        gap_d   = '0;
                        tout_d  = 1'b1;
                    end else begin
                        srch_d = srch_cnt + 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (beat) begin
                    if (smp_cnt == PW'(SYM_LEN - 1)) begin
                        smp_d = '0;
                        sym_d = sym_inc;
                        if (sym_inc >= n_lat) begin
                            state_d = DRAIN;
                            gap_d   = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        smp_d = smp_cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (gap_cnt == GW'(GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            arm_cnt     <= '0;
            srch_cnt    <= '0;
            smp_cnt     <= '0;
            gap_cnt     <= '0;
            sym_cnt     <= '0;
            n_lat       <= 8'd1;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            run_q       <= 1'b0;
            cyc_q       <= 1'b0;
        end else begin
            state       <= state_d;
            arm_cnt     <= arm_d;
            srch_cnt    <= srch_d;
            smp_cnt     <= smp_d;
            gap_cnt     <= gap_d;
            sym_cnt     <= sym_d;
            n_lat       <= nlat_d;
            frame_done  <= done_d;
            timeout_err <= tout_d;
            run_q       <= syn.syn_run;
            cyc_q       <= (state_d == ARM) || (state_d == SEARCH) ||
                           (state_d == PAYLOAD);
        end
    end

    assign syn.syn_cyc = cyc_q;
    assign busy        = (state != IDLE);
    assign state_o     = state;

endmodule

// File: tb/tb_rx_synch_ctrl.sv
// Directed bench for rx_synch_ctrl: normal frames, stalls, search and
// arm timeouts, enable drop, reset mid-search.
module tb_rx_synch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       pkt_det = 1'b0;
    logic [7:0] n_sym_cfg = 8'd0;
    logic       busy;
    logic [2:0] state_o;
    logic [7:0] sym_cnt;
    logic       frame_done;
    logic       timeout_err;

    int total = 0;
    int bad = 0;
    int fd_n = 0;
    int to_n = 0;
    int both_n = 0;

    rx_synch_ctrl_if s ();

    rx_synch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pkt_det     (pkt_det),
        .n_sym_cfg   (n_sym_cfg),
        .syn         (s.slave),
        .busy        (busy),
        .state_o     (state_o),
        .sym_cnt     (sym_cnt),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_n++;
        if (timeout_err) to_n++;
        if (frame_done && timeout_err) both_n++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] n);
        n_sym_cfg = n;
        pkt_det = 1'b1;
        step();
        pkt_det = 1'b0;
    endtask

    task automatic drain_idle(input string tag);
        int n;
        int hi;
        n = 0;
        hi = 0;
        do begin
            step();
            n++;
            if (s.syn_cyc) hi++;
        end while (state_o != 3'd0 && n < 64);
        chk({tag, "_len"}, n, 16);
        chk({tag, "_cyc_low"}, hi, 0);
    endtask

    initial begin
        int drop;
        int acked;
        int smp;
        int n;
        logic got;

        s.smp_val = 1'b0;
        s.syn_run = 1'b0;
        s.syn_stb = 1'b0;
        s.syn_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_state", state_o, 0);
        chk("rst_cyc", s.syn_cyc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sym", sym_cnt, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_tout", timeout_err, 0);

        // normal frame, 3 symbols, ack always high
        start_frame(8'd3);
        chk("a_arm", state_o, 1);
        chk("a_arm_cyc", s.syn_cyc, 1);
        chk("a_arm_busy", busy, 1);
        step();
        chk("a_arm_wait", state_o, 1);
        s.syn_run = 1'b1;
        step();
        chk("a_search", state_o, 2);
        s.smp_val = 1'b1;
        drop = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (!s.syn_cyc || state_o != 3'd2) drop++;
        end
        chk("a_search_hold", drop, 0);
        s.smp_val = 1'b0;
        s.syn_run = 1'b0;
        step();
        chk("a_payload", state_o, 3);
        chk("a_payload_cyc", s.syn_cyc, 1);
        s.syn_stb = 1'b1;
        s.syn_ack = 1'b1;
        for (int i = 1; i <= 3072; i++) begin
            step();
            if (i == 1024) chk("a_sym1", sym_cnt, 1);
            if (i == 3071) chk("a_no_early", frame_done, 0);
        end
        chk("a_done", frame_done, 1);
        chk("a_drain", state_o, 4);
        chk("a_sym3", sym_cnt, 3);
        chk("a_drain_cyc", s.syn_cyc, 0);
        s.syn_stb = 1'b0;
        s.syn_ack = 1'b0;
        drain_idle("a_drain");
        chk("a_sym_keep", sym_cnt, 3);

        // stalled frame, config changed after latch, pkt_det in payload
        start_frame(8'd3);
        n_sym_cfg = 8'd1;
        s.syn_run = 1'b1;
        step();
        s.syn_run = 1'b0;
        step();
        chk("b_payload", state_o, 3);
        pkt_det = 1'b1;
        step();
        pkt_det = 1'b0;
        chk("b_pkt_ign", state_o, 3);
        chk("b_sym0", sym_cnt, 0);
        s.syn_stb = 1'b1;
        acked = 0;
        n = 0;
        got = 1'b0;
        while (!got && n < 10000) begin
            s.syn_ack = (n % 2 == 0);
            step();
            if (s.syn_ack) acked++;
            n++;
            if (acked == 1024 && s.syn_ack) chk("b_sym1", sym_cnt, 1);
            got = frame_done;
        end
        chk("b_done", got, 1);
        chk("b_acked", acked, 3072);
        chk("b_sym3", sym_cnt, 3);
        s.syn_stb = 1'b0;
        s.syn_ack = 1'b0;
        drain_idle("b_drain");

        // search timeout, samples every other cycle
        start_frame(8'd3);
        s.syn_run = 1'b1;
        step();
        chk("c_search", state_o, 2);
        smp = 0;
        n = 0;
        got = 1'b0;
        while (!got && n < 6000) begin
            s.smp_val = (n % 2 == 0);
            step();
            if (s.smp_val) smp++;
            n++;
            got = timeout_err;
        end
        chk("c_tout", got, 1);
        chk("c_smp", smp, 2048);
        chk("c_drain", state_o, 4);
        chk("c_cyc", s.syn_cyc, 0);
        s.smp_val = 1'b0;
        drain_idle("c_drain");
        s.syn_run = 1'b0;

        // syn_run never rises: ARM gives up after 4 clk
        start_frame(8'd3);
        chk("d_arm", state_o, 1);
        step();
        step();
        step();
        chk("d_arm4", state_o, 1);
        step();
        chk("d_idle", state_o, 0);
        chk("d_tout", timeout_err, 1);
        chk("d_cyc", s.syn_cyc, 0);
        step();
        chk("d_tout_drop", timeout_err, 0);

        // reset in the middle of search
        start_frame(8'd2);
        s.syn_run = 1'b1;
        step();
        s.smp_val = 1'b1;
        step();
        step();
        chk("e_search", state_o, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        s.smp_val = 1'b0;
        s.syn_run = 1'b0;
        chk("e_state", state_o, 0);
        chk("e_cyc", s.syn_cyc, 0);
        chk("e_busy", busy, 0);

        // enable dropped in search: quiet drain
        start_frame(8'd2);
        s.syn_run = 1'b1;
        step();
        enable = 1'b0;
        step();
        chk("f_drain", state_o, 4);
        chk("f_tout", timeout_err, 0);
        enable = 1'b1;
        s.syn_run = 1'b0;
        drain_idle("f_drain");

        // n_sym_cfg of zero runs a single symbol
        start_frame(8'd0);
        s.syn_run = 1'b1;
        step();
        s.syn_run = 1'b0;
        step();
        s.syn_stb = 1'b1;
        s.syn_ack = 1'b1;
        for (int i = 1; i <= 1024; i++) begin
            step();
            if (i == 1023) chk("g_no_early", frame_done, 0);
        end
        chk("g_done", frame_done, 1);
        chk("g_sym1", sym_cnt, 1);
        s.syn_stb = 1'b0;
        s.syn_ack = 1'b0;
        drain_idle("g_drain");

        chk("pulse_done_n", fd_n, 3);
        chk("pulse_tout_n", to_n, 2);
        chk("pulse_both", both_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
